// File: rtl/exc_flush_ctrl_pkg.sv
// Shared constants for the WB-boundary exception sequencer: vectors, ExcCodes,
// FSM encoding and CP0 register numbers.
package exc_flush_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam int          CNT_DIV_DEF    = 2;

  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } state_t;

  function automatic logic int_pending_f(input logic ie, input logic exl,
                                         input logic [7:0] im, input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_flush_ctrl_cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every CNT_DIV clocks and a
// Count==Compare hit on a tick raises a sticky timer interrupt.
module exc_flush_ctrl_cp0_timer #(
  parameter int CNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int            DW       = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CNT_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // A software write to Count restarts the prescaler and beats the tick.
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + DW'(1);
      end

      if (cmp_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (tick && (count == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET commit sequencer at WB: strobes CP0, flushes the pipe and
// hands the redirect target to IF; also hosts the CP0 timer.
//   state   | meaning
//   S_IDLE  | watching WB for interrupt / exception / ERET commit
//   S_REDIR | flush held, redirect offered to IF until accepted
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_DIV    = CNT_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic        ws_eret,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] cp0_epc,
  input  logic        mtc0_count_we,
  input  logic        mtc0_cmp_we,
  input  logic [31:0] mtc0_wdata,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [31:0] exc_pc,
  output logic        eret_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        cause_ti
);

  state_t      state, state_nxt;
  logic        int_pending;
  logic        take;
  logic [31:0] take_target;

  assign int_pending = int_pending_f(status_ie, status_exl, status_im, cause_ip);
  assign exc_code    = int_pending ? EX_INT : ws_excode;
  assign exc_bd      = ws_bd;
  assign exc_pc      = ws_pc;

  always_comb begin
    state_nxt      = state;
    exc_commit     = 1'b0;
    eret_commit    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    take           = 1'b0;
    take_target    = EXC_VECTOR;
    case (state)
      S_IDLE: begin
        if (ws_valid && (int_pending || ws_ex)) begin
          exc_commit = 1'b1;
          take       = 1'b1;
        end else if (ws_valid && ws_eret) begin
          eret_commit = 1'b1;
          take        = 1'b1;
          take_target = cp0_epc;
        end
        flush = take;
        if (take) state_nxt = S_REDIR;
      end
      S_REDIR: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      if (take) redirect_pc <= take_target;
    end
  end

  exc_flush_ctrl_cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .count_we (mtc0_count_we),
    .cmp_we   (mtc0_cmp_we),
    .wdata    (mtc0_wdata),
    .count    (count),
    .compare  (compare),
    .ti       (cause_ti)
  );

endmodule
